multicycle_controller: RTL and testbench

- Main sequencing FSM for the multicycle ARM-subset datapath built from the core combinational library (adder, mux2/mux4, extender, register file, ALU).
- Decodes the instruction-register fields and steps the shared ALU/memory datapath through fetch, decode, execute and writeback.
- Handshakes with a variable-latency unified memory.
- Drives every datapath enable and mux select, including the extender's control input.

---
 rtl/multicycle_controller_pkg.sv | 56 +++++
 rtl/multicycle_controller_if.sv | 36 +++
 rtl/multicycle_controller_ctrl_output_decoder.sv | 90 +++++++++
 rtl/multicycle_controller.sv | 118 +++++++++++
 tb/tb_multicycle_controller.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// core_pkg: shared types and encodings for the multicycle controller slice.
// State encodings are explicit so unused codes can be recognised and recovered.
package core_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } ctrl_state_t;

  // instr[27:26] classes
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // result bus select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [3:0] REG_PC = 4'hF;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic [1:0] imm_src;
    logic       illegal_op;
  } ctrl_word_t;

  // Writes to r15 also redirect the PC.
  function automatic logic is_pc_dest(input logic [3:0] rd);
    return rd == REG_PC;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields, memory handshake and the
// datapath control word exchanged between the controller and the datapath.
interface multicycle_controller_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       cond_ex;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       alu_op;
  logic [1:0] imm_src;
  logic       illegal_op;

  // controller side
  modport master (
    input  op, funct, rd, cond_ex, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_op, imm_src, illegal_op
  );

  // datapath / memory side
  modport slave (
    output op, funct, rd, cond_ex, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_op, imm_src, illegal_op
  );
endinterface

// File: rtl/multicycle_controller_ctrl_output_decoder.sv
// ctrl_output_decoder: purely combinational map from FSM state plus
// qualifiers (op, rd, cond_ex, mem_ready, reset) to the datapath control word.
module ctrl_output_decoder
  import core_pkg::*;
(
  input  ctrl_state_t i_state,
  input  logic [1:0]  i_op,
  input  logic [3:0]  i_rd,
  input  logic        i_cond_ex,
  input  logic        i_mem_ready,
  input  logic        i_reset,
  output ctrl_word_t  o_ctrl
);

  logic w_pc_dest;
  assign w_pc_dest = is_pc_dest(i_rd);

  // Control word per state; write enables are killed while reset is held.
  always_comb begin
    o_ctrl         = '0;
    o_ctrl.imm_src = i_op;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_req    = 1'b1;
        o_ctrl.adr_src    = 1'b0;
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = SRCB_FOUR;
        o_ctrl.result_src = RES_ALURESULT;
        o_ctrl.ir_write   = i_mem_ready;
        o_ctrl.pc_write   = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_a  = 1'b1;
        o_ctrl.alu_src_b  = SRCB_FOUR;
        o_ctrl.result_src = RES_ALURESULT;
        o_ctrl.illegal_op = (i_op == OP_ILL);
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        o_ctrl.mem_req = 1'b1;
        o_ctrl.adr_src = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.result_src = RES_RDATA;
        o_ctrl.reg_write  = i_cond_ex;
        o_ctrl.pc_write   = i_cond_ex & w_pc_dest;
      end
      S_MEMWRITE: begin
        // a failed condition skips the access entirely
        o_ctrl.adr_src   = 1'b1;
        o_ctrl.mem_req   = i_cond_ex;
        o_ctrl.mem_write = i_cond_ex;
      end
      S_EXECUTER: begin
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = 1'b1;
      end
      S_EXECUTEI: begin
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = 1'b1;
      end
      S_ALUWB: begin
        o_ctrl.result_src = RES_ALUOUT;
        o_ctrl.reg_write  = i_cond_ex;
        o_ctrl.pc_write   = i_cond_ex & w_pc_dest;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a  = 1'b0;
        o_ctrl.alu_src_b  = SRCB_IMM;
        o_ctrl.result_src = RES_ALURESULT;
        o_ctrl.pc_write   = i_cond_ex;
      end
      default: ;
    endcase
    if (i_reset) begin
      o_ctrl.mem_req    = 1'b0;
      o_ctrl.mem_write  = 1'b0;
      o_ctrl.ir_write   = 1'b0;
      o_ctrl.pc_write   = 1'b0;
      o_ctrl.reg_write  = 1'b0;
      o_ctrl.illegal_op = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main sequencing FSM for the multicycle ARM-subset
// datapath. Optional counters instr_retired/stall_cycles exist only when
// CTRL_PERF_EN is defined.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
//   DECODE   | register read, ALU forms PC+8, dispatch on op
//   MEMADR   | ALUOut <= base + ExtImm
//   MEMREAD  | load request at ALUOut, hold until mem_ready
//   MEMWB    | write loaded data to rd
//   MEMWRITE | store request at ALUOut (skipped if cond fails)
//   EXECUTER | ALU on register operands
//   EXECUTEI | ALU on register A and ExtImm
//   ALUWB    | write ALUOut to rd
//   BRANCH   | PC <= PC+8 + ExtImm when cond passes
module multicycle_controller
  import core_pkg::*;
#(
  parameter int perf_width = 32
) (
  input  logic clk,
  input  logic reset,
  multicycle_controller_if.master ctrl_bus
`ifdef CTRL_PERF_EN
  ,
  output logic [perf_width-1:0] instr_retired,
  output logic [perf_width-1:0] stall_cycles
`endif
);

  if (perf_width < 1) begin : g_perf_width_check
    $error("perf_width must be at least 1");
  end

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;
  ctrl_word_t  w_ctrl;

  // State register; async reset returns to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_next;
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    w_state_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_state_next = ctrl_bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctrl_bus.op)
          OP_MEM:  w_state_next = S_MEMADR;
          OP_DP:   w_state_next = ctrl_bus.funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   w_state_next = S_BRANCH;
          default: w_state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   w_state_next = ctrl_bus.funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_state_next = ctrl_bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_state_next = S_FETCH;
      S_MEMWRITE: begin
        if (!ctrl_bus.cond_ex || ctrl_bus.mem_ready) w_state_next = S_FETCH;
        else                                         w_state_next = S_MEMWRITE;
      end
      S_EXECUTER: w_state_next = S_ALUWB;
      S_EXECUTEI: w_state_next = S_ALUWB;
      S_ALUWB:    w_state_next = S_FETCH;
      S_BRANCH:   w_state_next = S_FETCH;
      default:    w_state_next = S_FETCH;
    endcase
  end

  ctrl_output_decoder u_decoder (
    .i_state     (r_state),
    .i_op        (ctrl_bus.op),
    .i_rd        (ctrl_bus.rd),
    .i_cond_ex   (ctrl_bus.cond_ex),
    .i_mem_ready (ctrl_bus.mem_ready),
    .i_reset     (reset),
    .o_ctrl      (w_ctrl)
  );

  assign ctrl_bus.mem_req    = w_ctrl.mem_req;
  assign ctrl_bus.mem_write  = w_ctrl.mem_write;
  assign ctrl_bus.adr_src    = w_ctrl.adr_src;
  assign ctrl_bus.ir_write   = w_ctrl.ir_write;
  assign ctrl_bus.pc_write   = w_ctrl.pc_write;
  assign ctrl_bus.reg_write  = w_ctrl.reg_write;
  assign ctrl_bus.alu_src_a  = w_ctrl.alu_src_a;
  assign ctrl_bus.alu_src_b  = w_ctrl.alu_src_b;
  assign ctrl_bus.result_src = w_ctrl.result_src;
  assign ctrl_bus.alu_op     = w_ctrl.alu_op;
  assign ctrl_bus.imm_src    = w_ctrl.imm_src;
  assign ctrl_bus.illegal_op = w_ctrl.illegal_op;

`ifdef CTRL_PERF_EN
  logic [perf_width-1:0] r_instr_retired;
  logic [perf_width-1:0] r_stall_cycles;

  // Retire on every return to FETCH; stall on every unanswered request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_retired <= '0;
      r_stall_cycles  <= '0;
    end else begin
      if ((r_state != S_FETCH) && (w_state_next == S_FETCH))
        r_instr_retired <= r_instr_retired + 1'b1;
      if (w_ctrl.mem_req && !ctrl_bus.mem_ready)
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign instr_retired = r_instr_retired;
  assign stall_cycles  = r_stall_cycles;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a per-instruction phase model expands each
// instruction into the cycle-by-cycle control word it must produce.
module tb_multicycle_controller;

  logic clk;
  logic reset;

  multicycle_controller_if ctrl_bus ();

`ifdef CTRL_PERF_EN
  logic [31:0] instr_retired;
  logic [31:0] stall_cycles;
`endif

  multicycle_controller #(.perf_width(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .ctrl_bus (ctrl_bus)
`ifdef CTRL_PERF_EN
    ,
    .instr_retired (instr_retired),
    .stall_cycles  (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      ph;
    logic       rdy;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond;
    logic       mem_req, mem_write, ir_write, pc_write, reg_write, illegal, alu_op;
    logic       adr_src, a;
    logic [1:0] b, rs;
    bit         ck_adr, ck_a, ck_b, ck_rs;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   exp_ret = 0;
  int   exp_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic rec_t mk(input string ph, input logic [1:0] op, input logic [5:0] funct,
                              input logic [3:0] rd, input logic cond, input logic rdy);
    rec_t r;
    r.ph = ph; r.rdy = rdy; r.op = op; r.funct = funct; r.rd = rd; r.cond = cond;
    r.mem_req = 0; r.mem_write = 0; r.ir_write = 0; r.pc_write = 0; r.reg_write = 0;
    r.illegal = 0; r.alu_op = 0; r.adr_src = 0; r.a = 0; r.b = 0; r.rs = 0;
    r.ck_adr = 0; r.ck_a = 0; r.ck_b = 0; r.ck_rs = 0;
    return r;
  endfunction

  // Expand one instruction into its expected cycles; n = cycles appended.
  task automatic build(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                       input logic cond, input int fw, input int mw, output int n);
    rec_t r;
    bit   pcd;
    n   = 0;
    pcd = (rd == 4'hF);
    for (int i = 0; i <= fw; i++) begin
      r = mk("fetch", 2'($urandom), 6'($urandom), 4'($urandom), 1'($urandom), i == fw);
      r.mem_req = 1; r.ck_adr = 1; r.adr_src = 0;
      r.ck_a = 1; r.a = 1; r.ck_b = 1; r.b = 2'b10; r.ck_rs = 1; r.rs = 2'b10;
      r.ir_write = (i == fw); r.pc_write = (i == fw);
      q.push_back(r); n++;
    end
    r = mk("decode", op, funct, rd, cond, 1'($urandom));
    r.ck_a = 1; r.a = 1; r.ck_b = 1; r.b = 2'b10; r.ck_rs = 1; r.rs = 2'b10;
    r.illegal = (op == 2'b11);
    q.push_back(r); n++;
    if (op == 2'b00) begin
      r = mk("execute", op, funct, rd, cond, 1'($urandom));
      r.ck_a = 1; r.a = 0; r.ck_b = 1; r.b = funct[5] ? 2'b01 : 2'b00; r.alu_op = 1;
      q.push_back(r); n++;
      r = mk("aluwb", op, funct, rd, cond, 1'($urandom));
      r.ck_rs = 1; r.rs = 2'b00; r.reg_write = cond; r.pc_write = cond && pcd;
      q.push_back(r); n++;
    end else if (op == 2'b10) begin
      r = mk("branch", op, funct, rd, cond, 1'($urandom));
      r.ck_a = 1; r.a = 0; r.ck_b = 1; r.b = 2'b01; r.ck_rs = 1; r.rs = 2'b10;
      r.pc_write = cond;
      q.push_back(r); n++;
    end else if (op == 2'b01) begin
      r = mk("memadr", op, funct, rd, cond, 1'($urandom));
      r.ck_a = 1; r.a = 0; r.ck_b = 1; r.b = 2'b01;
      q.push_back(r); n++;
      if (funct[0]) begin
        for (int i = 0; i <= mw; i++) begin
          r = mk("memread", op, funct, rd, cond, i == mw);
          r.mem_req = 1; r.ck_adr = 1; r.adr_src = 1;
          q.push_back(r); n++;
        end
        r = mk("memwb", op, funct, rd, cond, 1'($urandom));
        r.ck_rs = 1; r.rs = 2'b01; r.reg_write = cond; r.pc_write = cond && pcd;
        q.push_back(r); n++;
      end else if (cond) begin
        for (int i = 0; i <= mw; i++) begin
          r = mk("memwrite", op, funct, rd, cond, i == mw);
          r.mem_req = 1; r.mem_write = 1; r.ck_adr = 1; r.adr_src = 1;
          q.push_back(r); n++;
        end
      end else begin
        r = mk("memwrite_skip", op, funct, rd, cond, 1'($urandom));
        r.ck_adr = 1; r.adr_src = 1;
        q.push_back(r); n++;
      end
    end
  endtask

  // Drive each expected cycle, compare at the falling edge, advance.
  task automatic run_queue();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      ctrl_bus.mem_ready = r.rdy;
      ctrl_bus.op        = r.op;
      ctrl_bus.funct     = r.funct;
      ctrl_bus.rd        = r.rd;
      ctrl_bus.cond_ex   = r.cond;
      @(negedge clk);
      chk({r.ph, ".mem_req"},    32'(ctrl_bus.mem_req),    32'(r.mem_req));
      chk({r.ph, ".mem_write"},  32'(ctrl_bus.mem_write),  32'(r.mem_write));
      chk({r.ph, ".ir_write"},   32'(ctrl_bus.ir_write),   32'(r.ir_write));
      chk({r.ph, ".pc_write"},   32'(ctrl_bus.pc_write),   32'(r.pc_write));
      chk({r.ph, ".reg_write"},  32'(ctrl_bus.reg_write),  32'(r.reg_write));
      chk({r.ph, ".illegal_op"}, 32'(ctrl_bus.illegal_op), 32'(r.illegal));
      chk({r.ph, ".alu_op"},     32'(ctrl_bus.alu_op),     32'(r.alu_op));
      chk({r.ph, ".imm_src"},    32'(ctrl_bus.imm_src),    32'(r.op));
      if (r.ck_adr) chk({r.ph, ".adr_src"},    32'(ctrl_bus.adr_src),    32'(r.adr_src));
      if (r.ck_a)   chk({r.ph, ".alu_src_a"},  32'(ctrl_bus.alu_src_a),  32'(r.a));
      if (r.ck_b)   chk({r.ph, ".alu_src_b"},  32'(ctrl_bus.alu_src_b),  32'(r.b));
      if (r.ck_rs)  chk({r.ph, ".result_src"}, 32'(ctrl_bus.result_src), 32'(r.rs));
`ifdef CTRL_PERF_EN
      chk("instr_retired", instr_retired, 32'(exp_ret));
      chk("stall_cycles",  stall_cycles,  32'(exp_stall));
`endif
      if (r.mem_req && !r.rdy) exp_stall++;
      // an instruction retires when the next queued cycle starts a fetch
      if (r.ph != "fetch" && (q.size() == 0 || q[0].ph == "fetch")) exp_ret++;
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  int n;

  initial begin
    reset = 1'b1;
    ctrl_bus.mem_ready = 1'b0;
    ctrl_bus.op = 2'b00; ctrl_bus.funct = 6'd0; ctrl_bus.rd = 4'd0; ctrl_bus.cond_ex = 1'b0;

    // reset state: enables off, FETCH selects
    #2;
    chk("rst.mem_req",    32'(ctrl_bus.mem_req),    32'd0);
    chk("rst.alu_src_a",  32'(ctrl_bus.alu_src_a),  32'd1);
    chk("rst.alu_src_b",  32'(ctrl_bus.alu_src_b),  32'd2);
    chk("rst.result_src", 32'(ctrl_bus.result_src), 32'd2);

    // reset asserted mid-fetch while memory is stalled
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("prefetch.mem_req", 32'(ctrl_bus.mem_req), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst.mem_req",  32'(ctrl_bus.mem_req),  32'd0);
    chk("midrst.ir_write", 32'(ctrl_bus.ir_write), 32'd0);
    chk("midrst.pc_write", 32'(ctrl_bus.pc_write), 32'd0);
    chk("midrst.adr_src",  32'(ctrl_bus.adr_src),  32'd0);
`ifdef CTRL_PERF_EN
    chk("midrst.instr_retired", instr_retired, 32'd0);
    chk("midrst.stall_cycles",  stall_cycles,  32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;

    // directed instructions; cycle counts pin the model's latencies
    build(2'b00, 6'b000000, 4'd3, 1'b1, 0, 0, n); chk("lat.add", 32'(n), 32'd4);
    build(2'b01, 6'b000001, 4'd5, 1'b1, 0, 2, n); chk("lat.ldr_wait2", 32'(n), 32'd7);
    build(2'b01, 6'b000000, 4'd2, 1'b0, 0, 0, n); chk("lat.str_nocond", 32'(n), 32'd4);
    build(2'b01, 6'b000000, 4'd2, 1'b1, 0, 0, n); chk("lat.str", 32'(n), 32'd4);
    build(2'b01, 6'b000001, 4'd1, 1'b1, 0, 0, n); chk("lat.ldr", 32'(n), 32'd5);
    build(2'b10, 6'b000000, 4'd0, 1'b1, 0, 0, n); chk("lat.b", 32'(n), 32'd3);
    build(2'b10, 6'b000000, 4'd0, 1'b0, 1, 0, n); chk("lat.b_wait1", 32'(n), 32'd4);
    build(2'b11, 6'b101010, 4'd7, 1'b1, 0, 0, n); chk("lat.illegal", 32'(n), 32'd2);
    build(2'b00, 6'b100000, 4'hF, 1'b1, 2, 0, n); chk("lat.addi_pc", 32'(n), 32'd6);
    build(2'b01, 6'b000001, 4'hF, 1'b1, 0, 1, n);
    run_queue();

    // randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      build(2'($urandom), 6'($urandom), 4'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0, n);
      if (q.size() > 40) run_queue();
    end
    run_queue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
